ddr2_req_queue: RTL and testbench

Client-side command front end for the DDR2 controller. Buffers read/write requests from the system in a small FIFO and presents them one at a time on the controller's client port (`c_addr`, `c_data_in`, `c_rd_req`, `c_wr_req`, `c_rdy`). It holds each request for exactly as long as the controller's handshake requires. On completion of a read it captures `c_data_out` and returns it to the requester.

---
 rtl/ddr2_req_queue.sv | 124 ++++++++++++
 tb/tb_ddr2_req_queue.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_req_queue.sv
// ddr2_req_queue: request FIFO and client-port sequencer
// feeding the DDR2 controller one command at a time.
module ddr2_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 26,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  input  logic                     c_rdy,
  input  logic [DATA_W-1:0]        c_data_out,
  output logic [ADDR_W-1:0]        c_addr,
  output logic [DATA_W-1:0]        c_data_in,
  output logic                     c_rd_req,
  output logic                     c_wr_req,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } state_t;

  state_t            state;
  logic              op_we;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              mem_we   [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              push;
  logic              pop;
  logic              live;

  // A pop never frees a slot for a same-cycle push.
  assign req_ready = (count != FULL);
  assign push      = req_valid & req_ready;
  assign pop       = (state == IDLE) & (count != '0);
  assign q_count   = count;
  assign busy      = (state != IDLE) | (count != '0);

  // HOLD drops the request as soon as c_rdy returns so the
  // controller cannot accept the same command twice.
  assign live     = (state == ISSUE) | ((state == HOLD) & ~c_rdy);
  assign c_rd_req = live & ~op_we;
  assign c_wr_req = live & op_we;

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_we[wr_ptr]   <= req_we;
      mem_addr[wr_ptr] <= req_addr;
      mem_data[wr_ptr] <= req_wdata;
    end
  end

  // Circular pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Command sequencer: pop, issue, hold until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_we     <= 1'b0;
      c_addr    <= '0;
      c_data_in <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            op_we     <= mem_we[rd_ptr];
            c_addr    <= mem_addr[rd_ptr];
            c_data_in <= mem_data[rd_ptr];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (c_rdy) state <= HOLD;
        end
        HOLD: begin
          if (c_rdy) begin
            if (!op_we) begin
              rsp_data  <= c_data_out;
              rsp_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_req_queue.sv
// tb_ddr2_req_queue: scoreboard bench with a controller model
// driving c_rdy/c_data_out against ddr2_req_queue.
module tb_ddr2_req_queue;

  localparam int AW = 26;
  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          c_rdy;
  logic [DW-1:0] c_data_out;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data_in;
  logic          c_rd_req;
  logic          c_wr_req;
  logic [2:0]    q_count;
  logic          busy;

  ddr2_req_queue #(
    .DEPTH (4),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .c_rdy     (c_rdy),
    .c_data_out(c_data_out),
    .c_addr    (c_addr),
    .c_data_in (c_data_in),
    .c_rd_req  (c_rd_req),
    .c_wr_req  (c_wr_req),
    .q_count   (q_count),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW+DW:0] exp_cmd[$];
  logic [DW-1:0]  exp_rsp[$];

  int            hold_n  = 8;
  int            tail_n  = 1;
  bit            stall   = 0;
  bit            use_fix = 0;
  logic [DW-1:0] fix     = '0;
  int            m_busy  = 0;
  int            m_tail  = 0;
  bit            m_first = 0;
  logic          cur_we  = 0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;
  int            accepts = 0;
  int            rsps    = 0;
  int            sim_pp  = 0;
  int            m_cnt   = 0;
  bit            pushed  = 0;
  bit            req_prev = 0;
  bit            rq;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic accept();
    logic [AW+DW:0] e;
    accepts++;
    if (exp_cmd.size() == 0) begin
      chk("acc_extra", 1, 0);
    end else begin
      e = exp_cmd.pop_front();
      cur_we   = e[AW+DW];
      cur_addr = e[AW+DW-1:DW];
      cur_data = e[DW-1:0];
      chk("acc_wr", c_wr_req, cur_we);
      chk("acc_rd", c_rd_req, !cur_we);
      chk("acc_addr", c_addr, cur_addr);
      if (cur_we) chk("acc_data", c_data_in, cur_data);
    end
    m_busy  = hold_n;
    m_tail  = tail_n;
    m_first = 1;
  endtask

  // push monitor, sampled just before the active edge
  always @(negedge clk) begin
    #4;
    if (rst) begin
      exp_cmd.delete();
      exp_rsp.delete();
      m_cnt  = 0;
      pushed = 0;
    end else begin
      pushed = req_valid && req_ready;
      if (pushed) exp_cmd.push_back({req_we, req_addr, req_wdata});
    end
  end

  // controller model plus occupancy tracking
  always @(negedge clk) begin
    #2;
    if (rst) begin
      c_rdy      = 0;
      c_data_out = '0;
      m_busy     = 0;
      m_tail     = 0;
      m_first    = 0;
      req_prev   = 0;
    end else begin
      if (m_busy > 0) begin
        c_rdy = 0;
        m_busy--;
        #1;
        chk("hold_rd", c_rd_req, !cur_we);
        chk("hold_wr", c_wr_req, cur_we);
        chk("hold_addr", c_addr, cur_addr);
        if (cur_we) chk("hold_data", c_data_in, cur_data);
      end else if (m_tail > 0) begin
        c_rdy = 1;
        c_data_out = use_fix ? fix : {6'h0, cur_addr, 32'h600D_F00D};
        if (m_first && !cur_we) exp_rsp.push_back(c_data_out);
        m_tail--;
        #1;
        if (m_first) begin
          chk("tail_rd", c_rd_req, 0);
          chk("tail_wr", c_wr_req, 0);
          m_first = 0;
        end else if (c_rd_req || c_wr_req) begin
          accept();
        end
      end else begin
        c_rdy = !stall;
        #1;
        if (c_rdy && (c_rd_req || c_wr_req)) accept();
      end
      rq = c_rd_req || c_wr_req;
      if (rq && !req_prev) m_cnt--;
      if (pushed) m_cnt++;
      if (rq && !req_prev && pushed) sim_pp++;
      req_prev = rq;
      chk("q_count", q_count, 64'(m_cnt));
    end
  end

  // response scoreboard
  always @(negedge clk) begin
    #1;
    if (rsp_valid) begin
      rsps++;
      if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
      else chk("rsp_data", rsp_data, exp_rsp.pop_front());
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_to", n < 100, 1);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || m_busy > 0 || m_tail > 0 || exp_cmd.size() > 0)
           && n < 300) begin
      @(negedge clk);
      #4;
      n++;
    end
    chk("drain", n < 300, 1);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rspv"}, rsp_valid, 0);
    chk({tag, "_rspd"}, rsp_data, 0);
    chk({tag, "_addr"}, c_addr, 0);
    chk({tag, "_din"}, c_data_in, 0);
    chk({tag, "_rd"}, c_rd_req, 0);
    chk({tag, "_wr"}, c_wr_req, 0);
    chk({tag, "_cnt"}, q_count, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int a0;
    int r0;
    int s0;
    int n;
    rst       = 1;
    req_valid = 0;
    req_we    = 0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    #4;
    chk_reset("rst");
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // single read
    use_fix = 1;
    fix     = 64'hDEAD_BEEF_0123_4567;
    hold_n  = 8;
    tail_n  = 1;
    a0 = accepts;
    r0 = rsps;
    send(0, 26'h0012345, 64'h0);
    req_valid = 0;
    @(negedge clk);
    #4;
    chk("lat_rd", c_rd_req, 1);
    chk("lat_wr", c_wr_req, 0);
    drain();
    chk("rd_acc", accepts - a0, 1);
    chk("rd_rsp", rsps - r0, 1);
    chk("rd_hold", rsp_data, 64'hDEAD_BEEF_0123_4567);

    // single write
    a0 = accepts;
    r0 = rsps;
    send(1, 26'h3FFFFFF, 64'hA5A5_A5A5_A5A5_A5A5);
    req_valid = 0;
    @(negedge clk);
    #4;
    chk("lat_wr2", c_wr_req, 1);
    chk("lat_rd2", c_rd_req, 0);
    drain();
    chk("wr_acc", accepts - a0, 1);
    chk("wr_rsp", rsps - r0, 0);

    // fill with controller stalled; 6th push must bounce
    use_fix = 0;
    stall   = 1;
    hold_n  = 2;
    a0 = accepts;
    r0 = rsps;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1;
      req_we    = i[0];
      req_addr  = 26'h100 + AW'(i);
      req_wdata = 64'hF000 + 64'(i);
      @(negedge clk);
    end
    req_valid = 0;
    #4;
    chk("full_rdy", req_ready, 0);
    chk("full_cnt", q_count, 4);
    stall = 0;
    drain();
    chk("fill_acc", accepts - a0, 5);
    chk("fill_cnt", q_count, 0);
    chk("fill_rsp", rsps - r0, 3);

    // wrap with overlapping push/pop
    hold_n = 0;
    tail_n = 1;
    a0 = accepts;
    s0 = sim_pp;
    for (int i = 0; i < 10; i++)
      send(i % 3 == 0, 26'h2000 + AW'(i * 7), 64'(i));
    req_valid = 0;
    drain();
    chk("wrap_acc", accepts - a0, 10);
    chk("wrap_sim", sim_pp > s0, 1);

    // completion with c_rdy high for 3 cycles
    hold_n = 2;
    tail_n = 3;
    a0 = accepts;
    send(1, 26'h0ABCDE, 64'h1122_3344_5566_7788);
    req_valid = 0;
    drain();
    chk("dbl_acc", accepts - a0, 1);

    // reset in the middle of HOLD with 2 queued
    hold_n = 20;
    tail_n = 1;
    a0 = accepts;
    r0 = rsps;
    for (int i = 0; i < 3; i++)
      send(0, 26'h30 + AW'(i), 64'h0);
    req_valid = 0;
    n = 0;
    while (accepts == a0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_acc_to", n < 20, 1);
    chk("mid_queued", q_count, 2);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    #4;
    chk_reset("mid");
    @(negedge clk);
    rst = 0;
    repeat (30) @(negedge clk);
    chk("mid_acc", accepts - a0, 1);
    chk("mid_rsp", rsps - r0, 0);
    chk("mid_cnt", q_count, 0);
    chk("mid_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
